inst_loader: RTL and testbench

Byte-stream writer that fills the instruction memory before the processor starts fetching. It accepts a framed byte stream over a valid/ready handshake, assembles big-endian 32-bit words, and issues single-cycle write strobes with word-aligned byte addresses. Addresses use the same convention as the fetch side (`Addr[9:2]` selects the word). It sits between a host link (UART/JTAG byte source) and the write port of the instruction RAM.

---
 rtl/inst_loader.sv | 166 ++++++++++++++++
 tb/tb_inst_loader.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/inst_loader.sv
// inst_loader: framed byte stream to instruction RAM write port.
// Optional trailer checksum: define INST_LOADER_CHECKSUM_EN.
module inst_loader #(
  parameter int DEPTH = 256
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Start,
  input  logic        InValid,
  input  logic [7:0]  InByte,
  output logic        InReady,
  output logic        WrEn,
  output logic [31:0] WrAddr,
  output logic [31:0] WrData,
  output logic        Busy,
  output logic        Done,
  output logic        Err,
  output logic [15:0] WordCount
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    IDLE,
    HDR_HI,
    HDR_LO,
    DATA,
`ifdef INST_LOADER_CHECKSUM_EN
    CHK,
`endif
    DONE,
    ERR
  } state_t;

  state_t        state;
  state_t        nxt;
  logic [7:0]    hi;
  logic [15:0]   n;
  logic [1:0]    lane;
  logic [23:0]   shift;
  logic [AW-1:0] idx;
  logic          load;
  logic          acc;
  logic          last;
  logic          hdr_bad;
  logic [15:0]   hdr_n;
`ifdef INST_LOADER_CHECKSUM_EN
  logic [7:0]    csum;
`endif

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= IDLE;
    else        state <= nxt;
  end

  assign acc     = InValid && Busy;
  assign InReady = Busy;
  assign hdr_n   = {hi, InByte};
  assign hdr_bad = (hdr_n == 16'd0) ||
                   ({1'b0, hdr_n} > 17'(DEPTH));
  assign last    = (WordCount + 16'd1) == n;

  always_comb begin
    nxt  = state;
    load = 1'b0;
    Busy = 1'b0;
    Done = 1'b0;
    Err  = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          nxt  = HDR_HI;
          load = 1'b1;
        end
      end
      HDR_HI: begin
        Busy = 1'b1;
        if (acc) nxt = HDR_LO;
      end
      HDR_LO: begin
        Busy = 1'b1;
        if (acc) nxt = hdr_bad ? ERR : DATA;
      end
      DATA: begin
        Busy = 1'b1;
        if (acc && lane == 2'd3 && last) begin
`ifdef INST_LOADER_CHECKSUM_EN
          nxt = CHK;
`else
          nxt = DONE;
`endif
        end
      end
`ifdef INST_LOADER_CHECKSUM_EN
      CHK: begin
        Busy = 1'b1;
        if (acc) nxt = (csum == InByte) ? DONE : ERR;
      end
`endif
      DONE: begin
        Done = 1'b1;
        if (Start) begin
          nxt  = HDR_HI;
          load = 1'b1;
        end
      end
      ERR: begin
        Err = 1'b1;
        if (Start) begin
          nxt  = HDR_HI;
          load = 1'b1;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  // Word assembly: earlier bytes shift toward [31:24].
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      hi        <= '0;
      n         <= '0;
      lane      <= '0;
      shift     <= '0;
      idx       <= '0;
      WrEn      <= 1'b0;
      WrAddr    <= '0;
      WrData    <= '0;
      WordCount <= '0;
    end else begin
      WrEn <= 1'b0;
      if (load) begin
        lane      <= '0;
        idx       <= '0;
        WordCount <= '0;
      end
      if (acc) begin
        case (state)
          HDR_HI: hi <= InByte;
          HDR_LO: n  <= hdr_n;
          DATA: begin
            lane  <= lane + 2'd1;
            shift <= {shift[15:0], InByte};
            if (lane == 2'd3) begin
              WrEn      <= 1'b1;
              WrData    <= {shift, InByte};
              WrAddr    <= 32'({idx, 2'b00});
              idx       <= idx + AW'(1);
              WordCount <= WordCount + 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef INST_LOADER_CHECKSUM_EN
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)                       csum <= '0;
    else if (load)                    csum <= '0;
    else if (acc && state == DATA)    csum <= csum ^ InByte;
  end
`endif

endmodule

// File: tb/tb_inst_loader.sv
// tb_inst_loader: directed vectors for inst_loader.
// Checksum cases are built when INST_LOADER_CHECKSUM_EN is defined.
module tb_inst_loader;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        Start = 1'b0;
  logic        InValid = 1'b0;
  logic [7:0]  InByte = '0;
  logic        InReady;
  logic        WrEn;
  logic [31:0] WrAddr;
  logic [31:0] WrData;
  logic        Busy;
  logic        Done;
  logic        Err;
  logic [15:0] WordCount;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] wa[$];
  logic [31:0] wd[$];
  logic [7:0]  frm[10];

  inst_loader #(.DEPTH(256)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start),
    .InValid(InValid), .InByte(InByte),
    .InReady(InReady), .WrEn(WrEn),
    .WrAddr(WrAddr), .WrData(WrData),
    .Busy(Busy), .Done(Done), .Err(Err),
    .WordCount(WordCount)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (WrEn === 1'b1) begin
      wa.push_back(WrAddr);
      wd.push_back(WrData);
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b, input bit gap);
    int t = 0;
    if (gap) begin
      InValid = 1'b0;
      tick(1);
    end
    InValid = 1'b1;
    InByte  = b;
    while (!InReady && t < 50) begin
      tick(1);
      t++;
    end
    if (t >= 50) check("rdy_timeout", 32'(InReady), 32'd1);
    tick(1);
    InValid = 1'b0;
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    tick(1);
    Start = 1'b0;
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_nwr"}, 32'(wa.size()), 32'd2);
    if (wa.size() == 2) begin
      check({tag, "_a0"}, wa[0], 32'h0);
      check({tag, "_d0"}, wd[0], 32'h00430820);
      check({tag, "_a1"}, wa[1], 32'h4);
      check({tag, "_d1"}, wd[1], 32'h00232022);
    end
  endtask

  task automatic finish_frame(input string tag);
    check({tag, "_wren_last"}, 32'(WrEn), 32'd1);
`ifdef INST_LOADER_CHECKSUM_EN
    check({tag, "_done_pre"}, 32'(Done), 32'd0);
    send(8'h4A, 1'b0);
`endif
    check({tag, "_done"}, 32'(Done), 32'd1);
    check({tag, "_wc"}, 32'(WordCount), 32'd2);
    tick(2);
    check_writes(tag);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_rdy"}, 32'(InReady), 32'd0);
    check({tag, "_wren"}, 32'(WrEn), 32'd0);
    check({tag, "_addr"}, WrAddr, 32'd0);
    check({tag, "_data"}, WrData, 32'd0);
    check({tag, "_flags"}, {29'd0, Busy, Done, Err}, 32'd0);
    check({tag, "_wc"}, 32'(WordCount), 32'd0);
  endtask

  initial begin
    frm = '{8'h00, 8'h02, 8'h00, 8'h43, 8'h08,
            8'h20, 8'h00, 8'h23, 8'h20, 8'h22};
    #3;
    check_reset("rst");
    Rst_n = 1'b1;
    tick(2);

    // back-to-back stream
    clear_log();
    pulse_start();
    check("t1_ready", 32'(InReady), 32'd1);
    for (int i = 0; i < 10; i++) send(frm[i], 1'b0);
    finish_frame("t1");

    // gapped stream
    clear_log();
    pulse_start();
    for (int i = 0; i < 10; i++) send(frm[i], 1'b1);
    finish_frame("t2");

    // zero-length header
    clear_log();
    pulse_start();
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    check("hz_err", 32'(Err), 32'd1);
    check("hz_rdy", 32'(InReady), 32'd0);
    tick(2);
    check("hz_nwr", 32'(wa.size()), 32'd0);

    // oversized header (257)
    pulse_start();
    send(8'h01, 1'b0);
    send(8'h01, 1'b0);
    check("hb_err", 32'(Err), 32'd1);
    check("hb_rdy", 32'(InReady), 32'd0);
    tick(2);
    check("hb_nwr", 32'(wa.size()), 32'd0);

`ifdef INST_LOADER_CHECKSUM_EN
    // bad trailer
    clear_log();
    pulse_start();
    for (int i = 0; i < 10; i++) send(frm[i], 1'b0);
    send(8'h00, 1'b0);
    check("ck_err", 32'(Err), 32'd1);
    check("ck_done", 32'(Done), 32'd0);
    tick(2);
    check_writes("ck");
`endif

    // reset after 6 data bytes
    clear_log();
    pulse_start();
    for (int i = 0; i < 8; i++) send(frm[i], 1'b0);
    check("mr_wc_pre", 32'(WordCount), 32'd1);
    #2;
    Rst_n = 1'b0;
    #1;
    check_reset("mr");
    check("mr_nwr", 32'(wa.size()), 32'd1);
    tick(2);
    Rst_n = 1'b1;
    tick(2);
    check("mr_nwr_post", 32'(wa.size()), 32'd1);

    // Start during DATA is ignored
    clear_log();
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      if (i == 4) Start = 1'b1;
      send(frm[i], 1'b0);
      Start = 1'b0;
    end
    finish_frame("sd");

    // Start in DONE restarts
    pulse_start();
    check("rs_wc", 32'(WordCount), 32'd0);
    check("rs_busy", 32'(Busy), 32'd1);
    check("rs_done", 32'(Done), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
